// File: rtl/life_row_renderer_if.sv
// rtl/life_row_renderer_if.sv - board memory read port between renderer and memory arbiter
interface life_row_renderer_if #(
  parameter int AW = 11
);
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_grant;
  logic          rd_data;

  // Renderer side: issues requests, receives grant and one-cycle-late data
  modport master (
    output rd_en,
    output rd_addr,
    input  rd_grant,
    input  rd_data
  );

  // Memory side: arbitrates requests and returns cell values
  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_grant,
    output rd_data
  );
endinterface

// File: rtl/life_row_renderer.sv
// rtl/life_row_renderer.sv - prefetches a board row in hblank and renders 8x8 cell icons
module life_row_renderer #(
  parameter int LOG_W       = 6,
  parameter int LOG_H       = 5,
  parameter int FRAME_X0    = 64,
  parameter int FRAME_Y0    = 112,
  parameter int FETCH_START = 640,
  parameter int H_LAST      = 799,
  parameter int V_LAST      = 524
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [9:0]                 hpos_i,
  input  logic [9:0]                 vpos_i,
  input  logic                       display_on_i,
  input  logic                       hsync_i,
  input  logic                       vsync_i,
  life_row_renderer_if.master        rd,
  output logic [1:0]                 r_o,
  output logic [1:0]                 g_o,
  output logic [1:0]                 b_o,
  output logic                       hsync_o,
  output logic                       vsync_o,
  output logic                       line_ready_o,
  output logic                       fetch_miss_o
);

  localparam int NCOL = 1 << LOG_W;

  // Timing constants sized to the 10-bit counters
  localparam logic [9:0] X0 = 10'(FRAME_X0);
  localparam logic [9:0] X1 = 10'(FRAME_X0 + 8 * (1 << LOG_W));
  localparam logic [9:0] Y0 = 10'(FRAME_Y0);
  localparam logic [9:0] Y1 = 10'(FRAME_Y0 + 8 * (1 << LOG_H));
  localparam logic [9:0] FS = 10'(FETCH_START);
  localparam logic [9:0] HL = 10'(H_LAST);
  localparam logic [9:0] VL = 10'(V_LAST);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [LOG_W-1:0]  col_q, col_d;
  logic [LOG_H-1:0]  row_q, row_d;
  logic [NCOL-1:0]   line_q;
  logic              cap_pend_q, cap_pend_d;
  logic [LOG_W-1:0]  cap_col_q, cap_col_d;
  logic              miss_q, miss_d;
  logic              rd_en_c, line_ready_c;

  logic [9:0]        nv;
  logic              trigger, deadline;

  logic              in_frame, pix_on;
  logic [LOG_W-1:0]  col_px;
  logic [7:0]        icon;
  logic [1:0]        r_d, g_d, b_d;

  // Cell icon: filled disc, one byte per icon row, bit index is the pixel column
  function automatic logic [7:0] icon_row(input logic [2:0] r);
    case (r)
      3'd0:    icon_row = 8'h00;
      3'd1:    icon_row = 8'h3C;
      3'd6:    icon_row = 8'h3C;
      3'd7:    icon_row = 8'h00;
      default: icon_row = 8'h7E;
    endcase
  endfunction

  // Fetch trigger: the line about to be displayed starts a new board row
  always_comb begin
    nv       = (vpos_i == VL) ? 10'd0 : vpos_i + 10'd1;
    trigger  = (hpos_i == FS) && (nv[2:0] == 3'd0) && (nv >= Y0) && (nv < Y1);
    deadline = (hpos_i == HL);
  end

  // Fetch FSM next state, request generation and capture scheduling
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    miss_d       = miss_q;
    cap_pend_d   = 1'b0;
    cap_col_d    = cap_col_q;
    rd_en_c      = 1'b0;
    line_ready_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = FETCH;
          col_d   = '0;
          row_d   = LOG_H'((nv - Y0) >> 3);
        end
      end
      FETCH: begin
        if (deadline) begin
          miss_d  = 1'b1;
          state_d = IDLE;
        end else begin
          rd_en_c = 1'b1;
          if (rd.rd_grant) begin
            cap_pend_d = 1'b1;
            cap_col_d  = col_q;
            col_d      = col_q + 1'b1;
            if (col_q == '1) state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // The final word lands this cycle via the pending capture
        if (deadline) begin
          miss_d = 1'b1;
        end else begin
          line_ready_c = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs forced low while reset is held so an abort is visible immediately
  always_comb begin
    rd.rd_en     = rd_en_c & ~reset_i;
    rd.rd_addr   = reset_i ? '0 : {row_q, col_q};
    line_ready_o = line_ready_c & ~reset_i;
    fetch_miss_o = miss_d & ~reset_i;
  end

  // FSM and fetch bookkeeping registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      miss_q     <= 1'b0;
      cap_pend_q <= 1'b0;
      cap_col_q  <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      miss_q     <= miss_d;
      cap_pend_q <= cap_pend_d;
      cap_col_q  <= cap_col_d;
    end
  end

  // Line buffer: data for an accepted request arrives one cycle later
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      line_q <= '0;
    end else if (cap_pend_q) begin
      line_q[cap_col_q] <= rd.rd_data;
    end
  end

  // Pixel colour from the buffered row and the icon ROM
  always_comb begin
    in_frame = display_on_i && (hpos_i >= X0) && (hpos_i < X1) &&
               (vpos_i >= Y0) && (vpos_i < Y1);
    col_px   = LOG_W'((hpos_i - X0) >> 3);
    icon     = icon_row(vpos_i[2:0]);
    pix_on   = line_q[col_px] & icon[hpos_i[2:0]];
    r_d      = 2'b00;
    g_d      = 2'b00;
    b_d      = 2'b00;
    if (in_frame) begin
      r_d = {pix_on, 1'b1};
      g_d = {pix_on, 1'b1};
      b_d = 2'b01;
    end else if (display_on_i) begin
      b_d = 2'b01;
    end
  end

  // Registered colour with syncs delayed by the same one cycle
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_o     <= 2'b00;
      g_o     <= 2'b00;
      b_o     <= 2'b00;
      hsync_o <= 1'b0;
      vsync_o <= 1'b0;
    end else begin
      r_o     <= r_d;
      g_o     <= g_d;
      b_o     <= b_d;
      hsync_o <= hsync_i;
      vsync_o <= vsync_i;
    end
  end

endmodule

// File: tb/tb_life_row_renderer.sv
// tb/tb_life_row_renderer.sv - directed and randomized checks of row fetch and icon rendering
module tb_life_row_renderer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] hpos, vpos;
  logic       disp, hs, vs;
  logic [1:0] r_o, g_o, b_o;
  logic       hsync_o, vsync_o, line_ready_o, fetch_miss_o;

  life_row_renderer_if rd ();

  life_row_renderer dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .hpos_i       (hpos),
    .vpos_i       (vpos),
    .display_on_i (disp),
    .hsync_i      (hs),
    .vsync_i      (vs),
    .rd           (rd),
    .r_o          (r_o),
    .g_o          (g_o),
    .b_o          (b_o),
    .hsync_o      (hsync_o),
    .vsync_o      (vsync_o),
    .line_ready_o (line_ready_o),
    .fetch_miss_o (fetch_miss_o)
  );

  always #5 clk = ~clk;

  bit          mem [2048];
  bit          exp_buf [64];
  bit          g [800];
  bit          miss_exp;
  bit          chk_pix;
  bit          chk_idle;
  logic [10:0] acc_addr [$];
  int          lr_cnt, lr_h;
  logic        miss799;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 800x525 timing: visible 640x480, hsync 656..751, vsync 490..491
  task automatic set_pos(input logic [9:0] h, input logic [9:0] v);
    hpos = h;
    vpos = v;
    disp = (h < 10'd640) && (v < 10'd480);
    hs   = (h >= 10'd656) && (h < 10'd752);
    vs   = (v >= 10'd490) && (v < 10'd492);
  endtask

  task automatic goto(input logic [9:0] h, input logic [9:0] v);
    set_pos(h, v);
    rd.rd_grant = g[h];
    #1;
  endtask

  // Expected colour of a pixel from the displayed-row model
  function automatic logic [5:0] exp_rgb(input logic [9:0] h, input logic [9:0] v, input logic d);
    int c;
    logic [7:0] ic;
    logic on;
    if (!d) return 6'b000000;
    if (h >= 64 && h < 576 && v >= 112 && v < 368) begin
      c = (int'(h) - 64) / 8;
      case (int'(v) % 8)
        0, 7:    ic = 8'h00;
        1, 6:    ic = 8'h3C;
        default: ic = 8'h7E;
      endcase
      on = exp_buf[c] & ic[int'(h) % 8];
      return {on, 1'b1, on, 1'b1, 2'b01};
    end
    return 6'b000001;
  endfunction

  // One pixel clock: sample combinational outputs, clock, check registered ones, advance
  task automatic step();
    logic [9:0]  ph, pv;
    logic        pd, phs, pvs, acc;
    logic [10:0] a;
    ph = hpos; pv = vpos; pd = disp; phs = hs; pvs = vs;
    acc = rd.rd_en & rd.rd_grant;
    a = rd.rd_addr;
    if (acc) acc_addr.push_back(a);
    if (line_ready_o) begin
      lr_cnt++;
      lr_h = int'(ph);
    end
    if (ph == 10'd799) miss799 = fetch_miss_o;
    if (chk_idle) chk("rd_en_idle", {31'd0, rd.rd_en}, 0);
    else if (ph < 10'd641 || ph == 10'd799) chk("rd_en_window", {31'd0, rd.rd_en}, 0);
    @(posedge clk);
    #1;
    rd.rd_data = acc ? mem[a] : 1'b0;
    if (chk_pix) begin
      chk("rgb", {26'd0, r_o, g_o, b_o}, {26'd0, exp_rgb(ph, pv, pd)});
      chk("sync", {30'd0, hsync_o, vsync_o}, {30'd0, phs, pvs});
    end
    if (ph == 10'd799) set_pos(10'd0, (pv == 10'd524) ? 10'd0 : pv + 10'd1);
    else set_pos(ph + 10'd1, pv);
    rd.rd_grant = g[hpos];
    #1;
  endtask

  // Run the fetch window of line v with a grant pattern and check the transaction
  task automatic run_fetch(input int v, input int mode);
    int row, n, last;
    bit complete;
    row = (v + 1 - 112) / 8;
    for (int h = 0; h < 800; h++) begin
      g[h] = 1'b1;
      if (h >= 641) begin
        case (mode)
          1: g[h] = ((h - 641) % 2) == 0;
          2: g[h] = $urandom_range(0, 3) != 0;
          3: g[h] = !(h <= 740);
          default: g[h] = 1'b1;
        endcase
      end
    end
    n = 0;
    last = -1;
    for (int h = 641; h <= 798; h++) begin
      if (g[h] && n < 64) begin
        n++;
        if (n == 64) last = h;
      end
    end
    complete = (n == 64) && (last <= 797);
    acc_addr.delete();
    lr_cnt = 0;
    lr_h = -1;
    chk_idle = 1'b0;
    goto(10'd630, 10'(v));
    repeat (170) step();
    chk("acc_count", acc_addr.size(), n);
    for (int i = 0; i < n; i++)
      chk("acc_addr", (i < acc_addr.size()) ? {21'd0, acc_addr[i]} : 32'hFFFF_FFFF, row * 64 + i);
    chk("lr_count", lr_cnt, {31'd0, complete});
    if (complete) chk("lr_hpos", lr_h, last + 1);
    if (!complete) miss_exp = 1'b1;
    chk("miss_at_799", {31'd0, miss799}, {31'd0, miss_exp});
    chk("fetch_miss", {31'd0, fetch_miss_o}, {31'd0, miss_exp});
    for (int i = 0; i < n; i++) exp_buf[i] = mem[row * 64 + i];
    for (int h = 0; h < 800; h++) g[h] = 1'b1;
    rd.rd_grant = 1'b1;
    #1;
  endtask

  // Whole line with per-pixel colour checks and no fetch activity expected
  task automatic scan_line(input int v);
    chk_idle = 1'b1;
    goto(10'd0, 10'(v));
    repeat (800) step();
    chk_idle = 1'b0;
  endtask

  task automatic run_nofetch(input int v);
    lr_cnt = 0;
    chk_idle = 1'b1;
    goto(10'd630, 10'(v));
    repeat (170) step();
    chk("nofetch_lr", lr_cnt, 0);
    chk_idle = 1'b0;
  endtask

  initial begin
    int i;
    for (int h = 0; h < 800; h++) g[h] = 1'b1;
    for (int a = 0; a < 2048; a++) mem[a] = (a < 64) ? ((a % 3) == 0) : 1'($urandom_range(0, 1));
    for (int c = 0; c < 64; c++) exp_buf[c] = 1'b0;
    miss_exp = 1'b0;
    chk_pix = 1'b0;
    chk_idle = 1'b1;
    rd.rd_data = 1'b0;
    goto(10'd0, 10'd0);

    // Reset state
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    chk("rst_rgb", {26'd0, r_o, g_o, b_o}, 0);
    chk("rst_sync", {30'd0, hsync_o, vsync_o}, 0);
    chk("rst_rd_en", {31'd0, rd.rd_en}, 0);
    chk("rst_line_ready", {31'd0, line_ready_o}, 0);
    chk("rst_fetch_miss", {31'd0, fetch_miss_o}, 0);
    chk_pix = 1'b1;

    // Row 0 with full grant, then view it
    run_fetch(111, 0);
    scan_line(113);
    // Row 5 with alternating grant
    run_fetch(151, 1);
    scan_line(155);
    // Row 6 with random grant
    run_fetch(159, 2);
    scan_line(163);
    // Row 7 starved past the deadline: partial update
    run_fetch(167, 3);
    scan_line(171);
    chk("miss_sticky", {31'd0, fetch_miss_o}, 1);

    // Lines whose successor is outside the board window
    run_nofetch(524);
    run_nofetch(367);
    chk("miss_still", {31'd0, fetch_miss_o}, 1);

    // Reset during a fetch at column 20
    lr_cnt = 0;
    chk_idle = 1'b0;
    goto(10'd630, 10'd111);
    i = 0;
    while (i < 100 && !(rd.rd_en && rd.rd_addr[5:0] == 6'd20)) begin
      step();
      i++;
    end
    chk("col20_reached", {31'd0, (i < 100)}, 1);
    chk_pix = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_mid_rd_en", {31'd0, rd.rd_en}, 0);
    step();
    reset = 1'b0;
    #1;
    for (int c = 0; c < 64; c++) exp_buf[c] = 1'b0;
    miss_exp = 1'b0;
    chk("rst_mid_rgb", {26'd0, r_o, g_o, b_o}, 0);
    chk("rst_mid_rd_en_after", {31'd0, rd.rd_en}, 0);
    chk("rst_mid_miss", {31'd0, fetch_miss_o}, 0);
    chk_pix = 1'b1;
    chk_idle = 1'b1;
    i = 0;
    while (i < 200 && hpos != 10'd0) begin
      step();
      i++;
    end
    chk("rst_mid_no_lr", lr_cnt, 0);
    scan_line(115);
    chk("final_miss", {31'd0, fetch_miss_o}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/life_row_renderer.md
Name: life_row_renderer

Overview:
- Display-side stage sitting directly downstream of the Life board memory and the `hvsync_generator` timing.
- Prefetches one 64-cell board row into an internal line buffer during horizontal blanking, through a granted 1-cycle-latency read port.
- Expands each cell to an 8x8 icon and drives registered 2-bit R/G/B with hsync/vsync delayed to match.
- Frees the board memory from combinational per-pixel reads, so the update engine owns memory outside the short fetch windows.

Parameters:
- LOG_W, 6, log2 board width in cells (64).
- LOG_H, 5, log2 board height in cells (32).
- FRAME_X0, 64, first active pixel column of the board window (multiple of 8).
- FRAME_Y0, 112, first active pixel line of the board window (multiple of 8).
- FETCH_START, 640, hpos at which a row fetch may begin.
- H_LAST, 799, last hpos of a line; fetch deadline.
- V_LAST, 524, last vpos of a frame.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high reset.
- hpos  in  10  current pixel column from `hvsync_generator`.
- vpos  in  10  current line from `hvsync_generator`.
- display_on  in  1  visible-region flag.
- hsync_in  in  1  raw hsync.
- vsync_in  in  1  raw vsync.
- rd_en  out  1  board read request.
- rd_addr  out  LOG_W+LOG_H  cell address {row, col}.
- rd_grant  in  1  request accepted this cycle.
- rd_data  in  1  cell value, valid the cycle after acceptance.
- R, G, B  out  2 each  registered colour.
- hsync_out, vsync_out  out  1 each  sync delayed 1 cycle.
- line_ready  out  1  one-cycle pulse when a row fetch completes.
- fetch_miss  out  1  sticky: a fetch missed its deadline.

Behaviour:
- Reset:
  - All outputs are 0.
  - FSM goes to IDLE and the line buffer clears to 0.
  - Reset asserted mid-fetch aborts the fetch immediately; no line_ready.
- Next line: nv = (vpos==V_LAST) ? 0 : vpos+1.
- Fetch trigger: hpos==FETCH_START, nv[2:0]==0, and FRAME_Y0 <= nv < FRAME_Y0+8*2^LOG_H.
  - row = (nv-FRAME_Y0)>>3, truncated to LOG_H bits.
- FSM states IDLE, FETCH, DRAIN:
  - IDLE -> FETCH on the trigger; col=0.
  - FETCH:
    - rd_en=1, rd_addr={row,col}.
    - Request is accepted only when rd_en&rd_grant. On acceptance col increments; otherwise address is held.
    - Acceptance of col=2^LOG_W-1 -> DRAIN.
  - Data capture: rd_data is written to buf[col of accepted request] exactly one cycle after acceptance. A pending capture completes even if the FSM changes state.
  - DRAIN: rd_en=0; the last word is captured; line_ready=1 for this cycle -> IDLE.
  - Deadline: if in FETCH or DRAIN at hpos==H_LAST before line_ready, set fetch_miss, rd_en=0, go IDLE. The buffer keeps partial contents (new for fetched columns, old for the rest).
- rd_en is never high in IDLE or DRAIN.
- Pixel path, one-cycle registered:
  - in_frame = display_on & FRAME_X0 <= hpos < FRAME_X0+8*2^LOG_W & vpos in the board window.
  - col_px = (hpos-FRAME_X0)>>3.
  - icon row/col = vpos[2:0], hpos[2:0]. Icon is a fixed internal ROM, rows 0..7: 00,3C,7E,7E,7E,7E,3C,00 (hex); bit index = hpos[2:0].
  - on = buf[col_px] & icon bit.
  - in_frame: R=G={on,1}, B=01.
  - display_on but not in_frame: R=G=00, B=01.
  - not display_on: R=G=B=00.
- hsync_out/vsync_out = hsync_in/vsync_in registered once, aligned with RGB.
- A fetch never overlaps visible pixels of the displayed row, because hpos>=640 is blanking, so a single buffer suffices.

Test Plan:
- Memory model with cell=(addr%3==0), rd_grant=1; run to vpos=111, hpos=640 -> rd_en for 64 cycles with rd_addr 0..63, line_ready at hpos=705, fetch_miss=0.
- Same model; vpos=112, hpos=64..71 delivered one cycle later -> R=G=11 at pixels 66..69 (icon row 0 is 00 -> actually pixels lit only for icon rows 1-6; check vpos=113: cols 66..69 R=11), B=01; hpos=72 (cell 1, value 0) -> R=G=01.
- rd_grant held low for 100 cycles after the trigger -> fetch_miss=1 at hpos=799; cells fetched keep new values, the rest keep old values; fetch_miss stays 1 until reset.
- rd_grant toggling 1,0,1,0 -> each address held until granted; all 64 cells correct; line_ready at hpos=768.
- vpos=V_LAST at hpos=640 -> no fetch (nv=0 outside window); vpos=367 -> no fetch for line 368.
- reset pulsed during FETCH at col=20 -> next cycle rd_en=0, RGB=0, buffer all 0, no line_ready.
